// File: rtl/lector_salida.sv
// lector_salida: egress reader for output FIFOs fifo4..fifo7.
// Watches the four empty flags, pops one non-empty FIFO at a time in
// round-robin order, captures the popped word and offers it downstream on a
// valid/ready handshake tagged with its source port. Keeps a per-port count
// of delivered words, readable through req/idx with one cycle of latency.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   empty[3:0]                 empty flags of fifo4..fifo7 (bit i = port i)
//   data_in0..data_in3         data_out of fifo4..fifo7
//   ready                      downstream accepts when valid && ready
//   pop[3:0]                   one-hot read_enable to fifo4..fifo7
//   data_out, port_out, valid  delivered word, its source port, word present
//   req, idx                   counter read request and counter select
//   cnt_out, cnt_valid         selected counter value, valid one cycle after req
module lector_salida #(
    parameter int TAMANO_DATOS = 12,
    parameter int CONT_W       = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              empty,
    input  logic [TAMANO_DATOS-1:0] data_in0,
    input  logic [TAMANO_DATOS-1:0] data_in1,
    input  logic [TAMANO_DATOS-1:0] data_in2,
    input  logic [TAMANO_DATOS-1:0] data_in3,
    input  logic                    ready,
    output logic [3:0]              pop,
    output logic [TAMANO_DATOS-1:0] data_out,
    output logic [1:0]              port_out,
    output logic                    valid,
    input  logic                    req,
    input  logic [1:0]              idx,
    output logic [CONT_W-1:0]       cnt_out,
    output logic                    cnt_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        CAPT = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [1:0]              sel;
    logic [1:0]              last;
    logic [CONT_W-1:0]       cnt [4];
    logic [TAMANO_DATOS-1:0] din [4];

    logic       pick_any;
    logic [1:0] pick;
    logic [1:0] cand;

    assign din[0] = data_in0;
    assign din[1] = data_in1;
    assign din[2] = data_in2;
    assign din[3] = data_in3;

    // Round-robin scan: first non-empty port starting just after the last
    // served one. k = 4 wraps back to 'last' itself, so a lone busy port
    // is still served back to back.
    always_comb begin
        pick_any = 1'b0;
        pick     = '0;
        cand     = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!pick_any && !empty[cand]) begin
                pick_any = 1'b1;
                pick     = cand;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = POP;
            POP:     state_nxt = CAPT;
            CAPT:    state_nxt = SEND;
            SEND:    if (ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        pop   = '0;
        valid = 1'b0;
        case (state)
            POP:     pop[sel] = 1'b1;
            SEND:    valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: port selection, word capture, round-robin pointer, counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel      <= '0;
            last     <= 2'd3;
            data_out <= '0;
            port_out <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (state == IDLE && pick_any) begin
                sel <= pick;
            end
            if (state == CAPT) begin
                data_out <= din[sel];
                port_out <= sel;
                cnt[sel] <= cnt[sel] + 1'b1;
                last     <= sel;
            end
        end
    end

    // Counter read port; a read in the same cycle as the capture of that
    // port sees the value before the increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_out   <= '0;
            cnt_valid <= 1'b0;
        end else begin
            cnt_valid <= req;
            if (req) begin
                cnt_out <= cnt[idx];
            end
        end
    end

endmodule

// File: tb/tb_lector_salida.sv
module tb_lector_salida;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  empty;
    logic [11:0] data_in0, data_in1, data_in2, data_in3;
    logic        ready;
    logic [3:0]  pop;
    logic [11:0] data_out;
    logic [1:0]  port_out;
    logic        valid;
    logic        req;
    logic [1:0]  idx;
    logic [4:0]  cnt_out;
    logic        cnt_valid;

    int errors = 0;
    int checks = 0;

    lector_salida #(.TAMANO_DATOS(12), .CONT_W(5)) dut (
        .clk(clk), .reset(reset), .empty(empty),
        .data_in0(data_in0), .data_in1(data_in1),
        .data_in2(data_in2), .data_in3(data_in3),
        .ready(ready), .pop(pop), .data_out(data_out), .port_out(port_out),
        .valid(valid), .req(req), .idx(idx), .cnt_out(cnt_out),
        .cnt_valid(cnt_valid)
    );

    always #5 clk = ~clk;

    // Transaction-level model: a delivery is an episode that starts when a
    // port is chosen; 'age' counts cycles since the choice. The pop is seen
    // one cycle later, the word is taken from the FIFO two cycles later and
    // is offered from then on until accepted.
    bit        m_busy;
    int        m_age;
    int        m_port;
    int        m_last;
    int        m_cnt [4];
    int        m_data;
    int        m_port_out;
    int        m_cnt_out;
    bit        m_cnt_valid;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_port = 0; m_last = 3;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_data = 0; m_port_out = 0; m_cnt_out = 0; m_cnt_valid = 0;
    endtask

    function automatic int din_of(input int p);
        case (p)
            0: return int'(data_in0);
            1: return int'(data_in1);
            2: return int'(data_in2);
            default: return int'(data_in3);
        endcase
    endfunction

    // Advance the model by one clock using the inputs the DUT is about to sample.
    task automatic model_step();
        if (req) begin
            m_cnt_out = m_cnt[idx];
        end
        m_cnt_valid = req;
        if (!m_busy) begin
            for (int k = 1; k <= 4; k++) begin
                int p;
                p = (m_last + k) % 4;
                if (!m_busy && !empty[p]) begin
                    m_busy = 1; m_age = 1; m_port = p;
                end
            end
        end else if (m_age == 2) begin
            m_data = din_of(m_port);
            m_port_out = m_port;
            m_cnt[m_port] = (m_cnt[m_port] + 1) % 32;
            m_last = m_port;
            m_age = 3;
        end else if (m_age >= 3) begin
            if (ready) m_busy = 0;
            else m_age++;
        end else begin
            m_age++;
        end
    endtask

    task automatic compare();
        int exp_pop;
        exp_pop = (m_busy && m_age == 1) ? (1 << m_port) : 0;
        chk("pop", int'(pop), exp_pop);
        chk("valid", int'(valid), int'(m_busy && m_age >= 3));
        chk("data_out", int'(data_out), m_data);
        chk("port_out", int'(port_out), m_port_out);
        chk("cnt_valid", int'(cnt_valid), int'(m_cnt_valid));
        chk("cnt_out", int'(cnt_out), m_cnt_out);
    endtask

    // Called at a falling edge: model consumes current inputs, one rising
    // edge passes, outputs are compared at the next falling edge.
    task automatic tick();
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        chk("rst_pop", int'(pop), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_port", int'(port_out), 0);
        chk("rst_cnt_out", int'(cnt_out), 0);
        chk("rst_cnt_valid", int'(cnt_valid), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic read_cnt(input int p, input int exp);
        req = 1'b1; idx = 2'(p);
        tick();
        chk("cnt_read_valid", int'(cnt_valid), 1);
        chk("cnt_read_val", int'(cnt_out), exp);
        req = 1'b0;
    endtask

    initial begin
        logic [11:0] w;
        int pops_seen;
        reset = 1'b1; empty = 4'hF; ready = 1'b1; req = 1'b0; idx = '0;
        data_in0 = 12'h111; data_in1 = 12'h222; data_in2 = 12'h333; data_in3 = 12'h444;
        @(negedge clk);
        apply_reset();

        // Single port: port 2 only
        empty = 4'b1011; data_in2 = 12'hA5C;
        tick();
        chk("single_pop", int'(pop), 4'b0100);
        empty = 4'hF;
        tick();
        chk("single_pop_off", int'(pop), 0);
        tick();
        chk("single_valid", int'(valid), 1);
        chk("single_data", int'(data_out), 12'hA5C);
        chk("single_port", int'(port_out), 2);
        tick();
        chk("single_valid_off", int'(valid), 0);

        // Round robin with all ports non-empty
        apply_reset();
        empty = 4'b0000; ready = 1'b1;
        for (int t = 1; t <= 17; t++) begin
            tick();
            chk("rr_pop", int'(pop), ((t - 1) % 4 == 0) ? (1 << (((t - 1) / 4) % 4)) : 0);
        end
        empty = 4'hF;
        for (int t = 0; t < 4; t++) tick();
        read_cnt(0, 2);
        read_cnt(1, 1);
        read_cnt(2, 1);
        read_cnt(3, 1);

        // Backpressure on port 0
        apply_reset();
        empty = 4'b1110; data_in0 = 12'h3C7; ready = 1'b0;
        tick(); tick(); tick();
        w = data_out;
        chk("bp_word", int'(w), 12'h3C7);
        data_in0 = 12'h0F0;
        for (int t = 0; t < 10; t++) begin
            tick();
            chk("bp_valid", int'(valid), 1);
            chk("bp_data", int'(data_out), int'(w));
            chk("bp_pop", int'(pop), 0);
        end
        // Reset while a word is being offered
        apply_reset();
        empty = 4'b1110; ready = 1'b0;
        tick(); tick(); tick();
        chk("bp2_valid", int'(valid), 1);
        ready = 1'b1;
        tick();
        chk("bp_hs_valid", int'(valid), 0);
        chk("bp_hs_pop", int'(pop), 0);
        tick();
        chk("bp_next_pop", int'(pop), 4'b0001);

        // Counter wrap on port 1 and read during capture
        apply_reset();
        empty = 4'b1101; ready = 1'b1;
        for (int t = 0; t < 33 * 4; t++) tick();
        empty = 4'hF;
        read_cnt(1, 1);
        empty = 4'b1101;
        tick(); tick();
        empty = 4'hF;
        read_cnt(1, 1);
        read_cnt(1, 2);

        // All empty
        for (int t = 0; t < 4; t++) tick();
        for (int t = 0; t < 20; t++) begin
            tick();
            chk("idle_pop", int'(pop), 0);
            chk("idle_valid", int'(valid), 0);
        end

        // Randomized traffic with occasional mid-operation resets
        pops_seen = 0;
        for (int t = 0; t < 3000; t++) begin
            empty    = 4'($urandom);
            ready    = ($urandom_range(0, 3) != 0);
            req      = ($urandom_range(0, 2) == 0);
            idx      = 2'($urandom);
            data_in0 = 12'($urandom);
            data_in1 = 12'($urandom);
            data_in2 = 12'($urandom);
            data_in3 = 12'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                apply_reset();
            end else begin
                tick();
                if (pop != 0) pops_seen++;
            end
        end
        chk("rand_activity", int'(pops_seen > 100), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/lector_salida.md
# lector_salida

Egress reader for the switch's four output FIFOs (fifo4..fifo7). Monitors their empty flags, issues one-hot pops in round-robin order, captures each popped word, and delivers it downstream over a valid/ready handshake tagged with its source port. Keeps a per-port count of words delivered, readable through a req/idx interface. Replaces the probador-driven pop_probador[3:0] path.

## Interface
- TAMANO_DATOS, 12, word width (class [11:10], dest [9:8], payload [7:0])
- CONT_W, 5, width of each per-port delivered-word counter
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- empty  input  4  empty flags of fifo4..fifo7 (bit i = port i)
- data_in0..data_in3  input  TAMANO_DATOS each  data_out of fifo4..fifo7
- ready  input  1  downstream accepts the word when valid && ready
- pop  output  4  one-hot read_enable to fifo4..fifo7
- data_out  output  TAMANO_DATOS  delivered word
- port_out  output  2  source port of data_out
- valid  output  1  data_out/port_out hold a word
- req  input  1  counter read request
- idx  input  2  counter select for req
- cnt_out  output  CONT_W  selected counter value
- cnt_valid  output  1  cnt_out valid this cycle

## Operation
- FSM states: IDLE, POP, CAPT, SEND. Reset state IDLE.
- IDLE: if any empty[i]==0, select first non-empty port scanning from (last+1) mod 4 upward, wrapping; record as sel; go POP. If all empty, stay IDLE.
- POP: pop[sel]=1 for exactly this cycle; all other pop bits 0; go CAPT.
- CAPT: FIFO output valid this cycle; register data_in[sel] into data_out, sel into port_out; increment counter[sel]; last<=sel; go SEND.
- SEND: valid=1; data_out/port_out stable. When ready==1, word is consumed; go IDLE. Otherwise hold indefinitely.
- pop is never asserted outside POP; at most one bit of pop high in any cycle; pop never asserted to a port whose empty was 1 when sampled in IDLE.
- Round-robin pointer last resets to 3, so first scan starts at port 0.
- Counters: CONT_W bits, wrap modulo 2^CONT_W (31 -> 0), no saturation.
- Counter read: req==1 at edge -> next cycle cnt_out=counter[idx], cnt_valid=1; otherwise cnt_valid=0, cnt_out holds last value. Read coinciding with CAPT increment of same port returns pre-increment value.
- Reset values: pop=0, valid=0, data_out=0, port_out=0, cnt_out=0, cnt_valid=0, all counters 0, last=3, state IDLE.
- Reset mid-operation (any state): all outputs return to reset values asynchronously; a word already popped but not delivered is dropped and not counted (counters cleared anyway).

## Timing
- Pop latency: port non-empty sampled in IDLE cycle N -> pop high in N+1 -> data_out/valid high from N+3.
- Minimum spacing between pops: 4 cycles (ready held high); each stall cycle with ready==0 in SEND adds one.
- valid deasserts the cycle after the ready handshake (IDLE cycle); next pop no earlier than 2 cycles after handshake.
- empty is only sampled in IDLE; changes in POP/CAPT/SEND are ignored until next IDLE.
- cnt_valid/cnt_out: 1-cycle latency from req, independent of FSM state.

## Test plan
- Reset: assert reset mid-SEND with valid=1 -> valid, pop, counters go 0 immediately; after release, first pop goes to port 0 if empty=4'b0000.
- Single port: empty=4'b1011 (port 2 has data 12'hA5C), ready=1 -> pop=4'b0100 one cycle, two cycles later data_out=12'hA5C, port_out=2, valid=1 for one cycle.
- Round robin: all ports non-empty continuously, ready=1 -> pop sequence 0001,0010,0100,1000,0001 at 4-cycle spacing; each counter reads 1 after first four words.
- Backpressure: ready=0 for 10 cycles in SEND -> valid and data_out stable, pop stays 4'b0000; ready=1 -> handshake, next pop 2 cycles later.
- Counter wrap/read: deliver 33 words from port 1, req=1 idx=1 -> cnt_out=1, cnt_valid=1 next cycle; req concurrent with CAPT of port 1 returns old value.
- All empty: empty=4'b1111 for 20 cycles -> FSM in IDLE, pop=0, valid=0 throughout.
